// File: rtl/sata_oob_if.sv
// sata_oob_if: bundles the OOB control/status, AXI-stream pass-through and GTX TX word signals
// of the SATA OOB burst sequencer.
//   oob_start/oob_type/oob_abort       request side (link layer -> sequencer)
//   oob_busy/oob_done/oob_err          status (sequencer -> link layer)
//   s_axi_tvalid/s_axi_tdata/tready    pass-through word stream
//   tx_data/tx_charisk/tx_elecidle     words to the transceiver
// The sequencer connects through the slave modport; the link layer side uses master.
interface sata_oob_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  oob_start;
  logic [1:0]            oob_type;
  logic                  oob_abort;
  logic                  oob_busy;
  logic                  oob_done;
  logic                  oob_err;
  logic                  s_axi_tvalid;
  logic [DATA_W-1:0]     s_axi_tdata;
  logic                  s_axi_tready;
  logic [DATA_W-1:0]     tx_data;
  logic [DATA_W/8-1:0]   tx_charisk;
  logic                  tx_elecidle;

  modport master (
    output oob_start, oob_type, oob_abort, s_axi_tvalid, s_axi_tdata,
    input  oob_busy, oob_done, oob_err, s_axi_tready, tx_data, tx_charisk, tx_elecidle
  );

  modport slave (
    input  oob_start, oob_type, oob_abort, s_axi_tvalid, s_axi_tdata,
    output oob_busy, oob_done, oob_err, s_axi_tready, tx_data, tx_charisk, tx_elecidle
  );
endinterface

// File: rtl/sata_oob_seq.sv
// sata_oob_seq: SATA out-of-band burst sequencer between the link layer and the GTX TX datapath.
// On request it emits COMRESET/COMINIT (long gap) or COMWAKE (short gap): BURST_CNT bursts of
// BURST_WORDS ALIGN primitives, each followed by an electrical-idle gap. While idle, valid
// AXI-stream words are passed straight through to the transceiver.
// Ports:
//   clk  TX word clock (txusrclk2)
//   rst  synchronous active-high reset
//   bus  sata_oob_if slave: request/status, pass-through stream, tx_* words
// All tx_* and oob_* outputs are registered; s_axi_tready is decoded from the state register.
module sata_oob_seq #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned BURST_CNT       = 6,
  parameter int unsigned BURST_WORDS     = 8,
  parameter int unsigned GAP_LONG_WORDS  = 24,
  parameter int unsigned GAP_SHORT_WORDS = 8,
  parameter logic [31:0] ALIGN_PRIM      = 32'h7B4A4ABC
) (
  input logic       clk,
  input logic       rst,
  sata_oob_if.slave bus
);

  localparam int unsigned KW       = DATA_W / 8;
  localparam int unsigned MaxBG    = (BURST_WORDS > GAP_LONG_WORDS) ? BURST_WORDS : GAP_LONG_WORDS;
  localparam int unsigned MaxWords = (MaxBG > GAP_SHORT_WORDS) ? MaxBG : GAP_SHORT_WORDS;
  localparam int unsigned WCW      = $clog2(MaxWords + 1);
  localparam int unsigned BCW      = $clog2(BURST_CNT + 1);

  localparam logic [WCW-1:0] WOne      = WCW'(1);
  localparam logic [WCW-1:0] BurstLast = WCW'(BURST_WORDS - 1);
  localparam logic [WCW-1:0] GapLong   = WCW'(GAP_LONG_WORDS);
  localparam logic [WCW-1:0] GapShort  = WCW'(GAP_SHORT_WORDS);
  localparam logic [BCW-1:0] BOne      = BCW'(1);
  localparam logic [BCW-1:0] BurstMax  = BCW'(BURST_CNT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [BCW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [WCW-1:0]    gap_len_q, gap_len_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [KW-1:0]     tx_charisk_q, tx_charisk_d;
  logic              tx_elecidle_q, tx_elecidle_d;

  logic [DATA_W-1:0] align_word;
  logic [KW-1:0]     align_k;

  // ALIGN replicated per 32-bit lane; K28.5 sits in byte 0 of every lane.
  always_comb begin
    align_word = '0;
    align_k    = '0;
    for (int i = 0; i < int'(KW); i++) begin
      align_word[8*i +: 8] = ALIGN_PRIM[8*(i%4) +: 8];
      align_k[i]           = ((i % 4) == 0);
    end
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q + WOne;
    burst_cnt_d = burst_cnt_q;
    gap_len_d   = gap_len_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        word_cnt_d = '0;
        if (bus.oob_start) begin
          if (bus.oob_type == 2'd3) begin
            err_d = 1'b1;
          end else begin
            gap_len_d   = (bus.oob_type == 2'd2) ? GapShort : GapLong;
            burst_cnt_d = '0;
            state_d     = StBurst;
          end
        end
      end
      StBurst: begin
        if (bus.oob_abort) begin
          state_d    = StIdle;
          word_cnt_d = '0;
        end else if (word_cnt_q == BurstLast) begin
          state_d     = StGap;
          word_cnt_d  = '0;
          burst_cnt_d = burst_cnt_q + BOne;
        end
      end
      StGap: begin
        if (bus.oob_abort) begin
          // Abort beats a coinciding final-gap completion: no done pulse.
          state_d    = StIdle;
          word_cnt_d = '0;
        end else if (word_cnt_q + WOne == gap_len_q) begin
          word_cnt_d = '0;
          if (burst_cnt_q < BurstMax) begin
            state_d = StBurst;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        word_cnt_d = '0;
      end
    endcase
  end

  // Output words are derived from the next state so they line up with the state register.
  always_comb begin
    tx_data_d     = '0;
    tx_charisk_d  = '0;
    tx_elecidle_d = 1'b1;
    if (state_d == StBurst) begin
      tx_data_d     = align_word;
      tx_charisk_d  = align_k;
      tx_elecidle_d = 1'b0;
    end else if ((state_q == StIdle) && (state_d == StIdle) && bus.s_axi_tvalid) begin
      // A word presented alongside an accepted start is dropped (state_d is BURST then).
      tx_data_d     = bus.s_axi_tdata;
      tx_elecidle_d = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      word_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      gap_len_q     <= GapLong;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      tx_data_q     <= '0;
      tx_charisk_q  <= '0;
      tx_elecidle_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      gap_len_q     <= gap_len_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      tx_data_q     <= tx_data_d;
      tx_charisk_q  <= tx_charisk_d;
      tx_elecidle_q <= tx_elecidle_d;
    end
  end

  assign bus.s_axi_tready = (state_q == StIdle) & ~rst;
  assign bus.oob_busy     = busy_q;
  assign bus.oob_done     = done_q;
  assign bus.oob_err      = err_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_charisk   = tx_charisk_q;
  assign bus.tx_elecidle  = tx_elecidle_q;

endmodule

// File: tb/tb_sata_oob_seq.sv
// tb_sata_oob_seq: directed bench for sata_oob_seq with default parameters.
// Inputs change 1 ns after the rising edge and outputs are sampled there too, so "cycle n"
// is the n-th edge after the request was presented.
module tb_sata_oob_seq;

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sata_oob_if #(.DATA_W(32)) bus ();

  sata_oob_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {tx_data, tx_charisk, tx_elecidle, oob_busy, oob_done, s_axi_tready}
  function automatic logic [39:0] obs();
    return {bus.tx_data, bus.tx_charisk, bus.tx_elecidle, bus.oob_busy, bus.oob_done,
            bus.s_axi_tready};
  endfunction

  function automatic logic [39:0] seq_exp(input int c, input int gap, input int last);
    logic al;
    if (c > last) return {32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1};
    al = (((c - 1) % (8 + gap)) < 8);
    return {al ? ALIGN : 32'h0, al ? 4'b0001 : 4'b0000, ~al, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0} || bus.oob_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got %h err=%b, want %h err=0", obs(), bus.oob_err,
               {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_axi_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready_release: got %b want 1", bus.s_axi_tready);
    end
  endtask

  task automatic test_passthrough();
    bus.s_axi_tvalid = 1'b1;
    bus.s_axi_tdata  = 32'h12345678;
    tick();
    checks++;
    if (obs() !== {32'h12345678, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL passthrough_word: got %h want %h", obs(),
               {32'h12345678, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    bus.s_axi_tdata = 32'hCAFEF00D;
    bus.oob_abort   = 1'b1;
    tick();
    checks++;
    if (bus.tx_data !== 32'hCAFEF00D || bus.tx_elecidle !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_abort_ignored: got %h/%b want cafef00d/0", bus.tx_data,
               bus.tx_elecidle);
    end
    bus.oob_abort    = 1'b0;
    bus.s_axi_tvalid = 1'b0;
    tick();
    checks++;
    if (obs() !== {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL passthrough_idle: got %h want %h", obs(), {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_illegal();
    bus.oob_start = 1'b1;
    bus.oob_type  = 2'd3;
    tick();
    bus.oob_start = 1'b0;
    checks++;
    if (bus.oob_err !== 1'b1 || bus.oob_busy !== 1'b0 || bus.tx_elecidle !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err_pulse: got err=%b busy=%b eidle=%b want 1/0/1", bus.oob_err,
               bus.oob_busy, bus.tx_elecidle);
    end
    tick();
    checks++;
    if (bus.oob_err !== 1'b0 || bus.oob_busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_clear: got err=%b busy=%b want 0/0", bus.oob_err, bus.oob_busy);
    end
  endtask

  // COMRESET with a second start (COMWAKE type) at cycle 50 that must be ignored.
  task automatic test_comreset();
    logic [39:0] e;
    bus.s_axi_tvalid = 1'b1;
    bus.s_axi_tdata  = 32'hDEADBEEF;
    bus.oob_start    = 1'b1;
    bus.oob_type     = 2'd0;
    tick();
    bus.s_axi_tvalid = 1'b0;
    for (int c = 1; c <= 194; c++) begin
      e = (c == 194) ? {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1} : seq_exp(c, 24, 192);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL comreset_cycle%0d: got %h want %h", c, obs(), e);
      end
      bus.oob_start = (c == 50);
      bus.oob_type  = (c == 50) ? 2'd2 : 2'd0;
      tick();
    end
  endtask

  task automatic test_comwake();
    logic [39:0] e;
    bus.oob_start = 1'b1;
    bus.oob_type  = 2'd2;
    tick();
    bus.oob_start = 1'b0;
    for (int c = 1; c <= 97; c++) begin
      e = seq_exp(c, 8, 96);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL comwake_cycle%0d: got %h want %h", c, obs(), e);
      end
      tick();
    end
  endtask

  // Abort on the 4th ALIGN of burst 3 (cycle 68), then a COMINIT must complete normally.
  task automatic test_abort();
    logic [39:0] e;
    int bad;
    bus.oob_start = 1'b1;
    bus.oob_type  = 2'd0;
    tick();
    bus.oob_start = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      e = seq_exp(c, 24, 192);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_pre_cycle%0d: got %h want %h", c, obs(), e);
      end
      bus.oob_abort = (c == 68);
      tick();
    end
    bus.oob_abort = 1'b0;
    checks++;
    if (obs() !== {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_next_cycle: got %h want %h", obs(), {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    end
    bad = 0;
    for (int c = 70; c <= 200; c++) begin
      tick();
      if (bus.oob_done !== 1'b0 || bus.tx_elecidle !== 1'b1 || bus.oob_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d bad cycles want 0", bad);
    end
    bus.oob_start = 1'b1;
    bus.oob_type  = 2'd1;
    tick();
    bus.oob_start = 1'b0;
    for (int c = 1; c <= 193; c++) begin
      e = seq_exp(c, 24, 192);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL cominit_cycle%0d: got %h want %h", c, obs(), e);
      end
      tick();
    end
  endtask

  // rst for one cycle in the gap of burst 2 (cycle 50).
  task automatic test_reset_mid();
    int bad;
    bus.oob_start = 1'b1;
    bus.oob_type  = 2'd0;
    tick();
    bus.oob_start = 1'b0;
    for (int c = 1; c < 50; c++) tick();
    checks++;
    if (obs() !== seq_exp(50, 24, 192)) begin
      errors++;
      $display("FAIL rstmid_pre: got %h want %h", obs(), seq_exp(50, 24, 192));
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0} || bus.oob_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_values: got %h err=%b want %h err=0", obs(), bus.oob_err,
               {32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 160; c++) begin
      tick();
      if (bus.oob_done !== 1'b0 || bus.oob_busy !== 1'b0 || bus.s_axi_tready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d bad cycles want 0", bad);
    end
    bus.s_axi_tvalid = 1'b1;
    bus.s_axi_tdata  = 32'hA5A55A5A;
    tick();
    bus.s_axi_tvalid = 1'b0;
    checks++;
    if (obs() !== {32'hA5A55A5A, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_passthrough: got %h want %h", obs(),
               {32'hA5A55A5A, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.oob_start    = 1'b0;
    bus.oob_type     = 2'd0;
    bus.oob_abort    = 1'b0;
    bus.s_axi_tvalid = 1'b0;
    bus.s_axi_tdata  = '0;
    test_reset();
    test_passthrough();
    test_illegal();
    test_comreset();
    test_comwake();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
